// File: rtl/keypad_scanner_if.sv
// CPU-side key FIFO port: read pulse in, head-of-queue, overflow flag and interrupt out.
interface keypad_scanner_if;
    logic       key_rd;
    logic       key_valid;
    logic [3:0] key_data;
    logic       key_ovf;
    logic       irq;

    modport master (output key_rd, input key_valid, key_data, key_ovf, irq);
    modport slave  (input key_rd, output key_valid, key_data, key_ovf, irq);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounce; each accepted press is queued as {row_idx, col_idx}.
// Codes appear on key_valid/key_data one cycle after the push edge; a push into a full FIFO without a pop is dropped.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       Keypad_rows,
    output logic [3:0]       Keypad_cols,
    keypad_scanner_if.slave  kbus
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

    state_t          state_q, state_d;
    logic [3:0]      rows_meta_q, rows_meta_d;
    logic [3:0]      rows_s_q, rows_s_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [1:0]      col_q, col_d;
    logic [3:0]      pat_q, pat_d;
    logic [CW-1:0]   match_q, match_d;
    logic [CW-1:0]   rel_q, rel_d;
    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [3:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            sample;
    logic            adv_col;
    logic            push_req;
    logic [CW-1:0]   match_inc;
    logic [CW-1:0]   rel_inc;
    logic [1:0]      row_idx;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic            drop;

    assign sample    = (dwell_q == DW'(SCAN_DIV - 1));
    assign match_inc = match_q + CW'(1);
    assign rel_inc   = rel_q + CW'(1);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SCAN;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (sample) begin
            case (state_q)
                SCAN:     if (rows_s_q != 4'hF) state_d = DEBOUNCE;
                DEBOUNCE: begin
                    if (rows_s_q != pat_q)                     state_d = SCAN;
                    else if (match_inc == CW'(DEBOUNCE_CNT))   state_d = PRESSED;
                end
                PRESSED:  if (rows_s_q == 4'hF && rel_inc == CW'(DEBOUNCE_CNT)) state_d = SCAN;
                default:  state_d = SCAN;
            endcase
        end
    end

    // FSM: outputs and debounce bookkeeping
    always_comb begin
        adv_col  = 1'b0;
        push_req = 1'b0;
        pat_d    = pat_q;
        match_d  = match_q;
        rel_d    = rel_q;
        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (rows_s_q == 4'hF) begin
                        adv_col = 1'b1;
                    end else begin
                        pat_d   = rows_s_q;
                        match_d = CW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (rows_s_q != pat_q) begin
                        adv_col = 1'b1;
                    end else begin
                        match_d = match_inc;
                        if (match_inc == CW'(DEBOUNCE_CNT)) begin
                            push_req = 1'b1;
                            rel_d    = '0;
                        end
                    end
                end
                PRESSED: begin
                    if (rows_s_q == 4'hF) begin
                        rel_d = rel_inc;
                        if (rel_inc == CW'(DEBOUNCE_CNT)) adv_col = 1'b1;
                    end else begin
                        rel_d = '0;
                    end
                end
                default: adv_col = 1'b0;
            endcase
        end
    end

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!pat_q[i]) row_idx = 2'(i);
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign pop        = kbus.key_rd && !fifo_empty;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    always_comb begin
        rows_meta_d = Keypad_rows;
        rows_s_d    = rows_meta_q;
        dwell_d     = sample ? '0 : dwell_q + DW'(1);
        col_d       = adv_col ? col_q + 2'd1 : col_q;
        mem_d       = mem_q;
        if (push) mem_d[wr_ptr_q] = {row_idx, col_q};
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop)      count_d = count_q + (PW+1)'(1);
        else if (pop && !push) count_d = count_q - (PW+1)'(1);
        ovf_d       = kbus.key_rd ? 1'b0 : (ovf_q | drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_meta_q <= 4'hF;
            rows_s_q    <= 4'hF;
            dwell_q     <= '0;
            col_q       <= 2'd0;
            pat_q       <= 4'hF;
            match_q     <= '0;
            rel_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'h0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            rows_meta_q <= rows_meta_d;
            rows_s_q    <= rows_s_d;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            pat_q       <= pat_d;
            match_q     <= match_d;
            rel_q       <= rel_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    assign Keypad_cols    = ~(4'b0001 << col_q);
    assign kbus.key_valid = !fifo_empty;
    assign kbus.key_data  = fifo_empty ? 4'h0 : mem_q[rd_ptr_q];
    assign kbus.key_ovf   = ovf_q;
    assign kbus.irq       = !fifo_empty;
endmodule
